// File: rtl/matrix_fb_arbiter.sv
// matrix_fb_arbiter
//   Owns the 8x8 LED-matrix frame buffer and its multiplexed row scan.
//   Two write requesters (d-pad editor, host row writer) share the single
//   frame-buffer write port through a round-robin req/gnt arbiter. An
//   internal clear sequencer wipes the buffer and blocks both requesters
//   while it runs. A blinking cursor is overlaid on the scanned output.
//
// Ports
//   clk                  system clock
//   rst                  asynchronous reset, active-low
//   ed_req/ed_x/ed_y     editor request, column and row
//   ed_op                01 set, 10 clear, 11 toggle, 00 no write
//   ed_gnt               one-cycle editor grant
//   host_req/host_row    host request and target row
//   host_data            host row value
//   host_gnt             one-cycle host grant
//   clr_start            single-cycle pulse that starts the clear
//   clr_busy             clear sequence running
//   cur_x/cur_y          cursor position
//   col                  column data, active-high, registered
//   row                  row select, active-low one-hot, registered
//
// Clear FSM
//   state | meaning
//   IDLE  | waiting for clr_start; arbiter free to grant
//   CLEAR | zeroing fb[idx], one row per clock, rows 0..7

module matrix_fb_arbiter #(
    parameter int SCAN_DIV  = 13,
    parameter int BLINK_BIT = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ed_req,
    input  logic [2:0] ed_x,
    input  logic [2:0] ed_y,
    input  logic [1:0] ed_op,
    output logic       ed_gnt,
    input  logic       host_req,
    input  logic [2:0] host_row,
    input  logic [7:0] host_data,
    output logic       host_gnt,
    input  logic       clr_start,
    output logic       clr_busy,
    input  logic [2:0] cur_x,
    input  logic [2:0] cur_y,
    output logic [7:0] col,
    output logic [7:0] row
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         idx;
    logic [2:0]         idx_nxt;
    logic               clr_we;

    logic [BLINK_BIT:0] cnt;
    logic [7:0]         fb [8];
    logic               last_host;

    logic               blocked;
    logic               ed_ok;
    logic               host_ok;
    logic               ed_win;
    logic               host_win;
    logic [7:0]         ed_mask;
    logic [7:0]         ed_row_new;

    logic [2:0]         sr;
    logic [7:0]         cursor;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    idx_nxt   = 3'd0;
                end
            end
            CLEAR: begin
                clr_we  = 1'b1;
                idx_nxt = idx + 3'd1;
                if (idx == 3'd7) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_busy = (state == CLEAR);

    // ---------------- arbiter ----------------
    // A start pulse seen in IDLE already blocks grants, so the clear
    // never shares its first edge with a requester write.
    assign blocked  = clr_busy || clr_start;
    // A requester whose gnt is high is ignored for one cycle so a held
    // req cannot be granted twice for the same payload.
    assign ed_ok    = ed_req && !ed_gnt;
    assign host_ok  = host_req && !host_gnt;
    assign ed_win   = !blocked && ed_ok && (!host_ok || last_host);
    assign host_win = !blocked && host_ok && !ed_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ed_gnt    <= 1'b0;
            host_gnt  <= 1'b0;
            last_host <= 1'b1;
        end else begin
            ed_gnt   <= ed_win;
            host_gnt <= host_win;
            if (ed_win) begin
                last_host <= 1'b0;
            end else if (host_win) begin
                last_host <= 1'b1;
            end
        end
    end

    // ---------------- frame buffer ----------------
    assign ed_mask = 8'd1 << ed_x;

    always_comb begin
        ed_row_new = fb[ed_y];
        case (ed_op)
            2'b01:   ed_row_new = fb[ed_y] | ed_mask;
            2'b10:   ed_row_new = fb[ed_y] & ~ed_mask;
            2'b11:   ed_row_new = fb[ed_y] ^ ed_mask;
            default: ed_row_new = fb[ed_y];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                fb[i] <= 8'h00;
            end
        end else if (clr_we) begin
            fb[idx] <= 8'h00;
        end else if (ed_win && (ed_op != 2'b00)) begin
            fb[ed_y] <= ed_row_new;
        end else if (host_win) begin
            fb[host_row] <= host_data;
        end
    end

    // ---------------- row scan ----------------
    assign sr     = cnt[SCAN_DIV+2:SCAN_DIV];
    assign cursor = (cnt[BLINK_BIT] && (sr == cur_y)) ? (8'd1 << cur_x) : 8'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            row <= 8'hFF;
            col <= 8'h00;
        end else begin
            cnt <= cnt + 1'b1;
            row <= ~(8'd1 << sr);
            col <= fb[sr] | cursor;
        end
    end

endmodule

// File: tb/tb_matrix_fb_arbiter.sv
// Testbench for matrix_fb_arbiter (SCAN_DIV=2, BLINK_BIT=5).
// A reference model steps once per clock edge from the block's behavioural
// rules (remaining-rows counter for the clear, round-robin choice, plain
// array for the frame buffer). Each grant it predicts is pushed into a
// scoreboard queue; a monitor on the falling edge pops and compares
// whenever the DUT shows a grant, and also compares row/col/clr_busy.

module tb_matrix_fb_arbiter;

    localparam int SD = 2;
    localparam int BB = 5;

    logic       clk;
    logic       rst;
    logic       ed_req;
    logic [2:0] ed_x;
    logic [2:0] ed_y;
    logic [1:0] ed_op;
    logic       ed_gnt;
    logic       host_req;
    logic [2:0] host_row;
    logic [7:0] host_data;
    logic       host_gnt;
    logic       clr_start;
    logic       clr_busy;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic [7:0] col;
    logic [7:0] row;

    matrix_fb_arbiter #(.SCAN_DIV(SD), .BLINK_BIT(BB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ed_req    (ed_req),
        .ed_x      (ed_x),
        .ed_y      (ed_y),
        .ed_op     (ed_op),
        .ed_gnt    (ed_gnt),
        .host_req  (host_req),
        .host_row  (host_row),
        .host_data (host_data),
        .host_gnt  (host_gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .col       (col),
        .row       (row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int unsigned edges;
    logic [7:0]  fb_m [8];
    int          clr_left;
    bit          last_host_m;
    bit          ed_g_m;
    bit          host_g_m;
    logic [7:0]  exp_row;
    logic [7:0]  exp_col;
    logic        exp_busy;
    logic [1:0]  sb_q [$];

    task automatic model_reset();
        edges = 0;
        for (int i = 0; i < 8; i++) fb_m[i] = 8'h00;
        clr_left    = 0;
        last_host_m = 1'b1;
        ed_g_m      = 1'b0;
        host_g_m    = 1'b0;
        exp_row     = 8'hFF;
        exp_col     = 8'h00;
        exp_busy    = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step();
        int  scan_row;
        bit  blink;
        bit  blk;
        bit  e_ok;
        bit  h_ok;
        bit  eg;
        bit  hg;
        logic [7:0] m;
        scan_row = (edges >> SD) % 8;
        blink    = ((edges >> BB) & 1) != 0;
        exp_row  = ~(8'd1 << scan_row);
        exp_col  = fb_m[scan_row];
        if (blink && scan_row == int'(cur_y)) exp_col = exp_col | (8'd1 << cur_x);
        edges = (edges + 1) % (1 << (BB + 1));

        blk = (clr_left > 0) || clr_start;
        if (clr_left > 0) begin
            fb_m[8 - clr_left] = 8'h00;
            clr_left--;
        end else if (clr_start) begin
            clr_left = 8;
        end

        eg = 1'b0;
        hg = 1'b0;
        if (!blk) begin
            e_ok = ed_req && !ed_g_m;
            h_ok = host_req && !host_g_m;
            if (e_ok && h_ok) begin
                if (last_host_m) eg = 1'b1;
                else hg = 1'b1;
            end else begin
                eg = e_ok;
                hg = h_ok;
            end
        end
        if (eg) begin
            m = 8'd1 << ed_x;
            case (ed_op)
                2'b01: fb_m[ed_y] = fb_m[ed_y] | m;
                2'b10: fb_m[ed_y] = fb_m[ed_y] & ~m;
                2'b11: fb_m[ed_y] = fb_m[ed_y] ^ m;
                default: ;
            endcase
            last_host_m = 1'b0;
            sb_q.push_back(2'b10);
        end
        if (hg) begin
            fb_m[host_row] = host_data;
            last_host_m    = 1'b1;
            sb_q.push_back(2'b01);
        end
        ed_g_m   = eg;
        host_g_m = hg;
        exp_busy = (clr_left > 0);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] mon_got;
    logic [1:0] mon_want;

    initial begin
        forever begin
            @(negedge clk);
            chk("row", row, exp_row);
            chk("col", col, exp_col);
            chk("clr_busy", clr_busy, exp_busy);
            mon_got = {ed_gnt, host_gnt};
            if (mon_got != 2'b00 || sb_q.size() != 0) begin
                mon_want = (sb_q.size() != 0) ? sb_q.pop_front() : 2'b00;
                chk("grant", mon_got, mon_want);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ed_write(input logic [2:0] x, input logic [2:0] y, input logic [1:0] op);
        int n;
        ed_req = 1'b1;
        ed_x   = x;
        ed_y   = y;
        ed_op  = op;
        n = 0;
        do begin
            step();
            n++;
        end while (!ed_gnt && n < 50);
        chk("ed_latency", n, 1);
        ed_req = 1'b0;
        step();
        chk("ed_gnt_width", ed_gnt, 1'b0);
    endtask

    task automatic host_write(input logic [2:0] r, input logic [7:0] d);
        int n;
        host_req  = 1'b1;
        host_row  = r;
        host_data = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!host_gnt && n < 50);
        chk("host_latency", n, 1);
        host_req = 1'b0;
        step();
        chk("host_gnt_width", host_gnt, 1'b0);
    endtask

    task automatic wait_row_col(input string name, input logic [7:0] target, input logic [7:0] want);
        int n;
        n = 0;
        while (row !== target && n < 100) begin
            step();
            n++;
        end
        chk({name, "_row_seen"}, row, target);
        chk(name, col, want);
    endtask

    logic [1:0] g_seq [8];
    int saw_a;
    int saw_b;
    int saw_other;
    int busy_cnt;
    int gnt_at;
    int nz;
    logic [7:0] msk;

    initial begin
        rst       = 1'b0;
        ed_req    = 1'b0;
        ed_x      = 3'd0;
        ed_y      = 3'd0;
        ed_op     = 2'b00;
        host_req  = 1'b0;
        host_row  = 3'd0;
        host_data = 8'h00;
        clr_start = 1'b0;
        cur_x     = 3'd0;
        cur_y     = 3'd7;

        // reset values, then first edges of the scan
        repeat (3) step();
        chk("rst_row", row, 8'hFF);
        chk("rst_col", col, 8'h00);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_gnt", {ed_gnt, host_gnt}, 2'b00);
        #1 rst = 1'b1;
        step();
        chk("first_row", row, 8'hFE);
        chk("first_col", col, 8'h00);
        repeat (3) step();
        chk("dwell_row0", row, 8'hFE);
        step();
        chk("dwell_row1", row, 8'hFD);

        // editor set / toggle / clear at (3,2)
        ed_write(3'd3, 3'd2, 2'b01);
        wait_row_col("ed_set", 8'hFB, 8'h08);
        ed_write(3'd3, 3'd2, 2'b11);
        wait_row_col("ed_toggle", 8'hFB, 8'h00);
        ed_write(3'd3, 3'd2, 2'b10);
        wait_row_col("ed_clear", 8'hFB, 8'h00);

        // both requesters held: grants alternate, host first (editor won last)
        ed_x = 3'd0; ed_y = 3'd0; ed_op = 2'b00;
        host_row = 3'd0; host_data = 8'h3C;
        ed_req = 1'b1; host_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            g_seq[i] = {ed_gnt, host_gnt};
        end
        ed_req = 1'b0; host_req = 1'b0;
        chk("tie_first", g_seq[0], 2'b01);
        for (int i = 0; i < 8; i++) begin
            chk("tie_onehot", (g_seq[i] == 2'b01 || g_seq[i] == 2'b10), 1'b1);
            if (i > 0) chk("tie_alternate", (g_seq[i] != g_seq[i-1]), 1'b1);
        end
        step();

        // host row 5 = A5 with cursor at (1,5): col shows A5 / A7
        cur_x = 3'd1; cur_y = 3'd5;
        host_write(3'd5, 8'hA5);
        saw_a = 0; saw_b = 0; saw_other = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (row == 8'hDF) begin
                if (col == 8'hA5) saw_a++;
                else if (col == 8'hA7) saw_b++;
                else saw_other++;
            end
        end
        chk("blink_off_seen", (saw_a > 0), 1'b1);
        chk("blink_on_seen", (saw_b > 0), 1'b1);
        chk("blink_other", saw_other, 0);

        // fill, then clear with an editor request pending
        for (int r = 0; r < 8; r++) host_write(3'(r), 8'hFF);
        ed_x = 3'd6; ed_y = 3'd6; ed_op = 2'b00;
        ed_req = 1'b1;
        clr_start = 1'b1;
        busy_cnt = 0;
        gnt_at = -1;
        for (int i = 0; i < 40 && gnt_at < 0; i++) begin
            step();
            if (i == 0) clr_start = 1'b0;
            if (i == 3) clr_start = 1'b1;
            if (i == 4) clr_start = 1'b0;
            if (clr_busy) busy_cnt++;
            if (ed_gnt) gnt_at = i;
        end
        ed_req = 1'b0;
        chk("clr_busy_cycles", busy_cnt, 8);
        chk("clr_gnt_edge", gnt_at, 9);
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            msk = (row == ~(8'd1 << cur_y)) ? ~(8'd1 << cur_x) : 8'hFF;
            if ((col & msk) != 8'h00) nz++;
        end
        chk("clr_all_zero", nz, 0);

        // reset in the middle of a clear
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (3) step();
        chk("pre_reset_busy", clr_busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", clr_busy, 1'b0);
        chk("midrst_row", row, 8'hFF);
        chk("midrst_col", col, 8'h00);
        chk("midrst_gnt", {ed_gnt, host_gnt}, 2'b00);
        repeat (2) step();
        #1 rst = 1'b1;
        step();
        chk("post_rst_row", row, 8'hFE);
        chk("post_rst_col", col, 8'h00);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!ed_req || ed_gnt) begin
                ed_req = ($urandom_range(0, 2) != 0);
                ed_x   = 3'($urandom_range(0, 7));
                ed_y   = 3'($urandom_range(0, 7));
                ed_op  = 2'($urandom_range(0, 3));
            end
            if (!host_req || host_gnt) begin
                host_req  = ($urandom_range(0, 2) != 0);
                host_row  = 3'($urandom_range(0, 7));
                host_data = 8'($urandom_range(0, 255));
            end
            clr_start = !clr_start && ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) begin
                cur_x = 3'($urandom_range(0, 7));
                cur_y = 3'($urandom_range(0, 7));
            end
            step();
        end
        ed_req = 1'b0; host_req = 1'b0; clr_start = 1'b0;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
